// File: rtl/uart_word_tx.sv
// uart_word_tx: serializes an NBYTES-wide word into 8N1 UART frames, MSB byte first,
// with its own baud timing and a valid/ready handshake.
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int NBYTES = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [8*NBYTES-1:0] DATA,
    input  logic                VALID,
    output logic                READY,
    output logic                TXD,
    output logic                BUSY,
    output logic                DONE
);
    localparam int W = 8 * NBYTES;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
    state_t       state;
    logic [15:0]  baud;
    logic [2:0]   bit_cnt;
    logic [7:0]   byte_cnt;
    logic [7:0]   shreg;
    logic [W-1:0] word;
    logic [W-1:0] next_word;
    logic         bit_end;
    assign bit_end   = baud == 16'(CLKS_PER_BIT - 1);
    assign next_word = word << 8;
    assign READY     = state == S_IDLE;
    assign BUSY      = ~READY;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            baud     <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            word     <= '0;
            TXD      <= 1'b1;
            DONE     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: if (VALID) begin
                    state    <= S_START;
                    word     <= DATA;
                    shreg    <= DATA[W-1 -: 8];
                    baud     <= '0;
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                end
                // first START cycle after acceptance only drops TXD, giving the one-cycle latency
                S_START: if (TXD) TXD <= 1'b0;
                else if (bit_end) begin
                    baud  <= '0;
                    state <= S_DATA;
                    TXD   <= shreg[0];
                end else baud <= baud + 16'd1;
                S_DATA: if (bit_end) begin
                    baud    <= '0;
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state <= S_STOP;
                        TXD   <= 1'b1;
                    end else TXD <= shreg[1];
                end else baud <= baud + 16'd1;
                S_STOP: if (bit_end) begin
                    baud <= '0;
                    if (byte_cnt == 8'(NBYTES - 1)) begin
                        state <= S_IDLE;
                        DONE  <= 1'b1;
                    end else begin
                        byte_cnt <= byte_cnt + 8'd1;
                        word     <= next_word;
                        shreg    <= next_word[W-1 -: 8];
                        state    <= S_START;
                        TXD      <= 1'b0;
                    end
                end else baud <= baud + 16'd1;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: directed bench with UART frame monitors and a byte scoreboard
// for two instances (4 and 2 clocks per bit).
module tb_uart_word_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] data4 = '0, data2 = '0;
    logic        valid4 = 1'b0, valid2 = 1'b0;
    logic        ready4, txd4, busy4, done4;
    logic        ready2, txd2, busy2, done2;
    logic [7:0]  q4[$], q2[$];
    int          checks = 0, errors = 0;
    int          n_done[2] = '{0, 0};
    time         t_acc[2], t_done[2];
    bit          mon_en = 1'b0;

    uart_word_tx #(.CLKS_PER_BIT(4), .NBYTES(8)) u4 (
        .CLK(clk), .RST_N(rst_n), .DATA(data4), .VALID(valid4),
        .READY(ready4), .TXD(txd4), .BUSY(busy4), .DONE(done4));
    uart_word_tx #(.CLKS_PER_BIT(2), .NBYTES(8)) u2 (
        .CLK(clk), .RST_N(rst_n), .DATA(data2), .VALID(valid2),
        .READY(ready2), .TXD(txd2), .BUSY(busy2), .DONE(done2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic txd_of(input int s);
        return s == 0 ? txd4 : txd2;
    endfunction

    task automatic pop_cmp(input int s, input logic [7:0] b);
        int sz;
        sz = s == 0 ? q4.size() : q2.size();
        chk($sformatf("byte_expected%0d", s), 64'(sz != 0), 1);
        if (sz != 0) chk($sformatf("byte_value%0d", s), b, s == 0 ? q4.pop_front() : q2.pop_front());
    endtask

    task automatic mon(input int s, input int c);
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && txd_of(s) === 1'b0) begin
                for (int k = 1; k < c; k++) begin @(negedge clk); chk("start_low", txd_of(s), 0); end
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    b[i] = txd_of(s);
                    for (int k = 1; k < c; k++) begin @(negedge clk); chk("bit_width", txd_of(s), b[i]); end
                end
                for (int k = 0; k < c; k++) begin @(negedge clk); chk("stop_high", txd_of(s), 1); end
                pop_cmp(s, b);
            end
        end
    endtask

    initial mon(0, 4);
    initial mon(1, 2);

    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            n_done[0]++;
            t_done[0] = $time;
            chk("ready_at_done4", ready4, 1);
        end
        if (done2 === 1'b1) begin
            n_done[1]++;
            t_done[1] = $time;
            chk("ready_at_done2", ready2, 1);
        end
    end

    task automatic send(input int s, input logic [63:0] d, input bit hold);
        @(negedge clk);
        if (s == 0) begin data4 = d; valid4 = 1'b1; end
        else begin data2 = d; valid2 = 1'b1; end
        for (int i = 7; i >= 0; i--) begin
            if (s == 0) q4.push_back(d[8*i +: 8]);
            else q2.push_back(d[8*i +: 8]);
        end
        t_acc[s] = $time + 5;
        if (!hold) begin
            @(negedge clk);
            if (s == 0) valid4 = 1'b0;
            else valid2 = 1'b0;
        end
    endtask

    task automatic wait_done(input int s, input int n, input int limit);
        int k = 0;
        while (n_done[s] < n && k < limit) begin @(negedge clk); #1; k++; end
        chk($sformatf("done_seen%0d", s), 64'(n_done[s] >= n), 1);
    endtask

    initial begin
        int n;
        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_txd", txd4, 1);
        chk("rst_ready", ready4, 1);
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_txd2", txd2, 1);
        rst_n = 1'b1;
        // reset mid start bit
        send(0, 64'hA5A5A5A5A5A5A5A5, 0);
        for (int k = 0; k < 6 && txd4 !== 1'b0; k++) @(negedge clk);
        chk("abort_in_start", txd4, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_txd", txd4, 1);
        chk("abort_ready", ready4, 1);
        chk("abort_busy", busy4, 0);
        chk("abort_done", done4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        q4.delete();
        q2.delete();
        mon_en = 1'b1;
        // single word, timing of DONE
        n = n_done[0];
        send(0, 64'h3031323334353637, 0);
        wait_done(0, n + 1, 400);
        chk("done_edge", t_done[0] - t_acc[0], 321 * 10 + 5);
        // data stability after acceptance
        send(0, 64'hDEADBEEFBAADF00D, 1);
        @(negedge clk);
        valid4 = 1'b0;
        data4 = 64'hFFFF_FFFF_FFFF_FFFF;
        wait_done(0, n + 2, 400);
        // VALID while busy is ignored
        send(0, 64'h0123456789ABCDEF, 0);
        repeat (48) @(negedge clk);
        data4 = '0; valid4 = 1'b1;
        @(negedge clk) valid4 = 1'b0;
        repeat (149) @(negedge clk);
        data4 = '0; valid4 = 1'b1;
        @(negedge clk) valid4 = 1'b0;
        wait_done(0, n + 3, 400);
        repeat (60) @(negedge clk);
        chk("busy_single_done", n_done[0], n + 3);
        chk("busy_no_extra", q4.size(), 0);
        chk("busy_idle_txd", txd4, 1);
        // back-to-back words with VALID held
        send(0, 64'h0001020304050607, 1);
        @(negedge clk);
        data4 = 64'h08090A0B0C0D0E0F;
        for (int i = 7; i >= 0; i--) q4.push_back(data4[8*i +: 8]);
        wait_done(0, n + 4, 400);
        chk("b2b_stop_end", txd4, 1);
        chk("b2b_ready", ready4, 1);
        @(negedge clk);
        #1;
        chk("b2b_accepted", ready4, 0);
        chk("b2b_busy", busy4, 1);
        chk("b2b_idle_cycle", txd4, 1);
        t_acc[0] = $time - 6;
        valid4 = 1'b0;
        @(negedge clk);
        #1;
        chk("b2b_start", txd4, 0);
        wait_done(0, n + 5, 400);
        chk("b2b_done_edge", t_done[0] - t_acc[0], 321 * 10 + 5);
        // edge patterns at two clocks per bit
        send(1, 64'h00FF55AA00FF55AA, 0);
        wait_done(1, 1, 200);
        chk("fast_done_edge", t_done[1] - t_acc[1], 161 * 10 + 5);
        repeat (20) @(negedge clk);
        chk("q4_empty", q4.size(), 0);
        chk("q2_empty", q2.size(), 0);
        chk("done_count4", n_done[0], n + 5);
        chk("done_count2", n_done[1], 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
